// File: rtl/encoder_4x2_event_if.sv
// Request/code handshake bundle for encoder_4x2_event.
// The slave modport is the encoder side and the master modport is the source/consumer side.
interface encoder_4x2_event_if;
  logic       enable;
  logic [3:0] in;
  logic [1:0] out;
  logic       valid;
  logic       ack;
  logic [3:0] pending;
  logic       overrun;

  modport slave  (input  enable, in, ack,
                  output out, valid, pending, overrun);
  modport master (output enable, in, ack,
                  input  out, valid, pending, overrun);
endinterface

// File: rtl/encoder_4x2_event.sv
// Edge-capturing 4-to-2 encoder with a sticky pending register and a valid/ack handshake.
// Define ENCODER_ROUND_ROBIN_EN for rotating priority; by default the highest index wins.
module encoder_4x2_event (
  input  logic                 clk,
  input  logic                 rst,
  encoder_4x2_event_if.slave   bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] in_q;
  logic [3:0] pending_q, pending_d;
  logic [1:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic [3:0] new_w;
  logic [3:0] grant_mask;
  logic [1:0] grant_idx;
  logic       grant_w;

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [1:0] last_grant_q, last_grant_d;
  logic [1:0] cand;
  logic       found;

  // Search descends from one below the previous grant, wrapping modulo 4.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_grant_q - 2'(k);
      if (!found && pending_q[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_w) last_grant_d = grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 2'd3;
    else     last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    grant_idx = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (pending_q[k]) grant_idx = 2'(k);
    end
  end
`endif

  assign new_w      = {4{bus.enable}} & bus.in & ~in_q;
  assign grant_w    = (state_q == IDLE) && (pending_q != '0);
  assign grant_mask = grant_w ? (4'b0001 << grant_idx) : '0;

  // A fresh edge on the bit being granted re-sets it, so the OR follows the clear.
  assign pending_d = (pending_q & ~grant_mask) | new_w;
  assign overrun_d = overrun_q | ((new_w & pending_q & ~grant_mask) != '0);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (grant_w) begin
          out_d   = grant_idx;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_q      <= '0;
      pending_q <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_q      <= bus.in;
      pending_q <= pending_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;

endmodule
